// File: rtl/cam_fb_writer.sv
// Drains the camera output FIFO into a double-buffered frame buffer, one
// sequential address per pixel, flipping the write bank on each complete frame.
module cam_fb_writer #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 19
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_sof,
  input  logic [DATA_WIDTH-1:0] i_obuf_data,
  input  logic                  i_obuf_empty,
  output logic                  o_obuf_rd,
  output logic                  o_fb_wr,
  output logic [ADDR_WIDTH:0]   o_fb_addr,
  output logic [DATA_WIDTH-1:0] o_fb_wdata,
  output logic                  o_wr_bank,
  output logic                  o_rd_bank,
  output logic                  o_frame_done,
  output logic                  o_frame_err,
  output logic [7:0]            o_frame_cnt
);

  localparam int unsigned FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int unsigned CNT_W        = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_PIX = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_SOF = 2'd1;
  localparam logic [1:0] S_ACTIVE   = 2'd2;
  localparam logic [1:0] S_FLUSH    = 2'd3;

  logic [1:0]            state, state_nxt;
  logic [CNT_W-1:0]      rd_cnt, rd_cnt_nxt;
  logic [CNT_W-1:0]      wr_cnt, wr_cnt_nxt;
  logic                  rd_pend, rd_pend_nxt;
  logic                  fb_wr_nxt;
  logic [ADDR_WIDTH:0]   fb_addr_nxt;
  logic [DATA_WIDTH-1:0] fb_wdata_nxt;
  logic                  wr_bank_nxt, rd_bank_nxt;
  logic                  done_nxt, err_nxt;
  logic [7:0]            frame_cnt_nxt;
  logic                  start_c, rd_allow_c, frame_full_c;

  // Read enable follows i_obuf_empty directly so a single buffered word is never over-read.
  always_comb begin
    frame_full_c = (rd_cnt == FULL_PIX);
    start_c      = i_enable & i_sof & (state != S_IDLE);
    rd_allow_c   = i_enable & ~i_rst &
                   (start_c | (state == S_WAIT_SOF) | ((state == S_ACTIVE) & (rd_cnt < FULL_PIX)));
    o_obuf_rd    = rd_allow_c & ~i_obuf_empty;
  end

  always_comb begin
    state_nxt     = state;
    rd_cnt_nxt    = rd_cnt;
    wr_cnt_nxt    = wr_cnt;
    rd_pend_nxt   = o_obuf_rd & (start_c | (state == S_ACTIVE));
    fb_wr_nxt     = rd_pend & ~start_c;
    fb_addr_nxt   = o_fb_addr;
    fb_wdata_nxt  = o_fb_wdata;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    wr_bank_nxt   = o_wr_bank;
    rd_bank_nxt   = o_rd_bank;
    frame_cnt_nxt = o_frame_cnt;

    // Write stage: data returned for last cycle's read goes out this edge.
    if (fb_wr_nxt) begin
      fb_addr_nxt  = {o_wr_bank, wr_cnt[ADDR_WIDTH-1:0]};
      fb_wdata_nxt = i_obuf_data;
      wr_cnt_nxt   = wr_cnt + CNT_W'(1);
      done_nxt     = (wr_cnt == LAST_PIX);
    end

    if (o_frame_done) begin
      wr_bank_nxt   = ~o_wr_bank;
      rd_bank_nxt   = o_wr_bank;
      frame_cnt_nxt = o_frame_cnt + 8'd1;
    end

    // A start-of-frame restarts counting; the read taken in this cycle is pixel 0.
    if (start_c) begin
      state_nxt  = S_ACTIVE;
      rd_cnt_nxt = CNT_W'(o_obuf_rd);
      wr_cnt_nxt = '0;
      err_nxt    = (state != S_WAIT_SOF) & (rd_cnt != '0) &
                   ~((state == S_FLUSH) & frame_full_c & ~rd_pend);
    end else begin
      case (state)
        S_IDLE: begin
          if (i_enable) state_nxt = S_WAIT_SOF;
        end
        S_WAIT_SOF: begin
          if (!i_enable) state_nxt = S_IDLE;
        end
        S_ACTIVE: begin
          if (!i_enable) begin
            state_nxt = S_FLUSH;
          end else if (o_obuf_rd) begin
            rd_cnt_nxt = rd_cnt + CNT_W'(1);
            if (rd_cnt_nxt == FULL_PIX) state_nxt = S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (!rd_pend) state_nxt = i_enable ? S_WAIT_SOF : S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      rd_pend      <= 1'b0;
      o_fb_wr      <= 1'b0;
      o_fb_addr    <= '0;
      o_fb_wdata   <= '0;
      o_wr_bank    <= 1'b0;
      o_rd_bank    <= 1'b1;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      state        <= state_nxt;
      rd_cnt       <= rd_cnt_nxt;
      wr_cnt       <= wr_cnt_nxt;
      rd_pend      <= rd_pend_nxt;
      o_fb_wr      <= fb_wr_nxt;
      o_fb_addr    <= fb_addr_nxt;
      o_fb_wdata   <= fb_wdata_nxt;
      o_wr_bank    <= wr_bank_nxt;
      o_rd_bank    <= rd_bank_nxt;
      o_frame_done <= done_nxt;
      o_frame_err  <= err_nxt;
      o_frame_cnt  <= frame_cnt_nxt;
    end
  end

endmodule
